// File: rtl/universal_shift_burst.sv
// rtl/universal_shift_burst.sv - universal shift register with start/busy/done burst engine
// Seven per-cycle modes plus a burst FSM that applies one shift/rotate mode cnt times.
module universal_shift_burst #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [2:0]       bmode_q, bmode_d;
  logic [CW-1:0]    rem_q, rem_d;

  logic [2:0]       op_mode;
  logic [WIDTH-1:0] op_q;
  logic             op_sout;
  logic             burst_ok;

  // While bursting the latched mode drives the datapath; live mode is ignored.
  assign op_mode  = (state_q == SHIFT) ? bmode_q : mode;
  assign burst_ok = (cnt != '0) && (mode >= 3'b001) && (mode <= 3'b101);

  always_comb begin
    op_q    = q_q;
    op_sout = sout_q;
    case (op_mode)
      3'b001: begin op_q = {q_q[WIDTH-2:0], sin};      op_sout = q_q[WIDTH-1]; end
      3'b010: begin op_q = {sin, q_q[WIDTH-1:1]};      op_sout = q_q[0];       end
      3'b011: begin op_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; op_sout = q_q[WIDTH-1]; end
      3'b100: begin op_q = {q_q[0], q_q[WIDTH-1:1]};   op_sout = q_q[0];       end
      3'b101: begin op_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; op_sout = q_q[0];   end
      3'b110: op_q = din;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    bmode_d = bmode_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_ok) begin
            state_d = SHIFT;
            bmode_d = mode;
            rem_d   = cnt;
          end else begin
            state_d = DONE;
          end
        end else if (en) begin
          q_d    = op_q;
          sout_d = op_sout;
        end
      end
      SHIFT: begin
        q_d    = op_q;
        sout_d = op_sout;
        rem_d  = rem_q - CW'(1);
        if (rem_q == CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      bmode_q <= 3'b000;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      bmode_q <= bmode_d;
      rem_q   <= rem_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_universal_shift_burst.sv
// tb/tb_universal_shift_burst.sv - directed bench for universal_shift_burst (WIDTH=4, CW=3)
module tb_universal_shift_burst;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       en;
  logic [2:0] mode;
  logic       sin;
  logic [3:0] din;
  logic       start;
  logic [2:0] cnt;
  logic [3:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int pass_cnt = 0;
  int total_cnt = 0;

  universal_shift_burst #(.WIDTH(4), .CW(3)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .sin(sin), .din(din),
    .start(start), .cnt(cnt), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    start = 1'b0; en = 1'b1; mode = 3'b110; din = v;
    tick();
    en = 1'b0; mode = 3'b000;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; en = 1'b0; mode = 3'b000; sin = 1'b0; din = 4'h0; start = 1'b0; cnt = 3'd0;
    tick();
    total_cnt++; if (q !== 4'b0000) $display("FAIL reset_q got %b want 0000", q); else pass_cnt++;
    total_cnt++; if ({sout, busy, done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {sout, busy, done}); else pass_cnt++;
    clr_n = 1'b1;
    load(4'b1111);
    start = 1'b1; mode = 3'b001; cnt = 3'd7; sin = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL reset_preburst_busy got %b want 1", busy); else pass_cnt++;
    #2 clr_n = 1'b0;
    #1;
    total_cnt++; if ({q, sout, busy, done} !== 7'b0000000) $display("FAIL reset_async got %b want 0000000", {q, sout, busy, done}); else pass_cnt++;
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_no_done cyc %0d got %b want 00", i, {busy, done}); else pass_cnt++;
    end
  endtask

  task automatic test_load_shift();
    load(4'b1011);
    total_cnt++; if (q !== 4'b1011) $display("FAIL load_q got %b want 1011", q); else pass_cnt++;
    en = 1'b1; mode = 3'b001; sin = 1'b0;
    tick();
    total_cnt++; if ({q, sout} !== 5'b0110_1) $display("FAIL shl got %b want 01101", {q, sout}); else pass_cnt++;
    mode = 3'b010; sin = 1'b1;
    tick();
    total_cnt++; if ({q, sout} !== 5'b1011_0) $display("FAIL shr got %b want 10110", {q, sout}); else pass_cnt++;
    mode = 3'b000; sin = 1'b0;
    tick();
    total_cnt++; if ({q, sout} !== 5'b1011_0) $display("FAIL hold got %b want 10110", {q, sout}); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_asr_rotr();
    load(4'b1000);
    en = 1'b1; mode = 3'b101; sin = 1'b0;
    tick();
    total_cnt++; if ({q, sout} !== 5'b1100_0) $display("FAIL asr1 got %b want 11000", {q, sout}); else pass_cnt++;
    tick();
    total_cnt++; if ({q, sout} !== 5'b1110_0) $display("FAIL asr2 got %b want 11100", {q, sout}); else pass_cnt++;
    load(4'b0001);
    en = 1'b1; mode = 3'b100;
    tick();
    total_cnt++; if ({q, sout} !== 5'b1000_1) $display("FAIL rotr got %b want 10001", {q, sout}); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_burst();
    load(4'b1001);
    start = 1'b1; mode = 3'b011; cnt = 3'd3; sin = 1'b0;
    tick();
    start = 1'b0; mode = 3'b000;
    total_cnt++; if ({q, busy, done} !== 6'b1001_10) $display("FAIL burst_e0 got %b want 100110", {q, busy, done}); else pass_cnt++;
    tick();
    total_cnt++; if ({q, sout, busy, done} !== 7'b0011_1_10) $display("FAIL burst_e1 got %b want 0011110", {q, sout, busy, done}); else pass_cnt++;
    tick();
    total_cnt++; if ({q, sout, busy, done} !== 7'b0110_0_10) $display("FAIL burst_e2 got %b want 0110010", {q, sout, busy, done}); else pass_cnt++;
    tick();
    total_cnt++; if ({q, sout, busy, done} !== 7'b1100_0_01) $display("FAIL burst_e3 got %b want 1100001", {q, sout, busy, done}); else pass_cnt++;
    tick();
    total_cnt++; if ({q, busy, done} !== 6'b1100_00) $display("FAIL burst_idle got %b want 110000", {q, busy, done}); else pass_cnt++;
  endtask

  task automatic test_degenerate();
    start = 1'b1; mode = 3'b001; cnt = 3'd0; sin = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if ({q, busy, done} !== 6'b1100_01) $display("FAIL cnt0_done got %b want 110001", {q, busy, done}); else pass_cnt++;
    tick();
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL cnt0_idle got %b want 00", {busy, done}); else pass_cnt++;
    start = 1'b1; mode = 3'b110; cnt = 3'd5; din = 4'b0101;
    tick();
    start = 1'b0;
    total_cnt++; if ({q, sout, busy, done} !== 7'b1100_0_01) $display("FAIL load_mode_done got %b want 1100001", {q, sout, busy, done}); else pass_cnt++;
    tick();
    total_cnt++; if ({q, busy, done} !== 6'b1100_00) $display("FAIL load_mode_idle got %b want 110000", {q, busy, done}); else pass_cnt++;
  endtask

  task automatic test_collisions();
    start = 1'b1; en = 1'b1; mode = 3'b001; cnt = 3'd2; sin = 1'b1; din = 4'b0000;
    tick();
    total_cnt++; if ({q, busy} !== 5'b1100_1) $display("FAIL coll_start_en got %b want 11001", {q, busy}); else pass_cnt++;
    mode = 3'b110; cnt = 3'd7;
    tick();
    total_cnt++; if ({q, sout, busy, done} !== 7'b1001_1_10) $display("FAIL coll_busy1 got %b want 1001110", {q, sout, busy, done}); else pass_cnt++;
    sin = 1'b0;
    tick();
    total_cnt++; if ({q, sout, busy, done} !== 7'b0010_1_01) $display("FAIL coll_busy2 got %b want 0010101", {q, sout, busy, done}); else pass_cnt++;
    mode = 3'b001; sin = 1'b1;
    tick();
    total_cnt++; if ({q, busy, done} !== 6'b0010_00) $display("FAIL coll_done_ignore got %b want 001000", {q, busy, done}); else pass_cnt++;
    tick();
    total_cnt++; if ({q, busy, done} !== 6'b0010_10) $display("FAIL coll_restart got %b want 001010", {q, busy, done}); else pass_cnt++;
    start = 1'b0; en = 1'b0;
    clr_n = 1'b0;
    #2 clr_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_asr_rotr();
    test_burst();
    test_degenerate();
    test_collisions();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
